trig_gate_gen: RTL and testbench

- Downstream consumer of the rising-edge filter's one-cycle pulses.
- Each accepted pulse becomes a programmable trigger gate: a fixed delay, then a gate of configurable width, then a deadtime during which new pulses are vetoed.
- Keeps saturating accepted and vetoed pulse counts for the register readout path of the Top CDT.

---
 rtl/trig_gate_gen.sv | 136 +++++++++++++
 tb/tb_trig_gate_gen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/trig_gate_gen.sv
`default_nettype none
// ============================================================================
// Module   : trig_gate_gen
// Function : Turns accepted one-cycle pulses into delay/gate/deadtime trigger
//            gates and keeps saturating accept/veto counters.
// Revision : 1.0 - initial release
// ============================================================================
module trig_gate_gen #(
    parameter int DLY_W = 8,
    parameter int WID_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_pulse,
    input  logic             enable,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic [DLY_W-1:0] cfg_dead,
    input  logic             count_clr,
    output logic             gate_out,
    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] veto_cnt
);

    localparam int TW = (DLY_W > WID_W) ? DLY_W : WID_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DELAY = 2'd1,
        S_GATE  = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TW-1:0]      r_tmr;
    logic [TW-1:0]      w_tmr_nxt;
    logic [WID_W-1:0]   r_width_m1;
    logic [DLY_W-1:0]   r_dead;
    logic [WID_W-1:0]   w_cfg_width_m1;
    logic               w_accept;
    logic               w_veto;

    // Width is stored minus one so that a programmed 0 behaves like 1.
    assign w_cfg_width_m1 = (cfg_width == '0) ? '0 : cfg_width - WID_W'(1);
    assign w_accept       = in_pulse & enable & (r_state == S_IDLE);
    assign w_veto         = in_pulse & busy;

    // r_tmr holds the remaining cycles of the current state minus one.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cfg_delay != '0) begin
                        w_state_nxt = S_DELAY;
                        w_tmr_nxt   = TW'(cfg_delay) - TW'(1);
                    end else begin
                        w_state_nxt = S_GATE;
                        w_tmr_nxt   = TW'(w_cfg_width_m1);
                    end
                end
            end
            S_DELAY: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_GATE;
                    w_tmr_nxt   = TW'(r_width_m1);
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            S_GATE: begin
                if (r_tmr == '0) begin
                    if (r_dead != '0) begin
                        w_state_nxt = S_DEAD;
                        w_tmr_nxt   = TW'(r_dead) - TW'(1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            S_DEAD: begin
                if (r_tmr == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_width_m1 <= '0;
            r_dead     <= '0;
            gate_out   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tmr    <= w_tmr_nxt;
            gate_out <= (w_state_nxt == S_GATE);
            busy     <= (w_state_nxt != S_IDLE);
            if (w_accept) begin
                r_width_m1 <= w_cfg_width_m1;
                r_dead     <= cfg_dead;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || count_clr) begin
            accept_cnt <= '0;
            veto_cnt   <= '0;
        end else begin
            if (w_accept && (accept_cnt != {CNT_W{1'b1}})) begin
                accept_cnt <= accept_cnt + CNT_W'(1);
            end
            if (w_veto && (veto_cnt != {CNT_W{1'b1}})) begin
                veto_cnt <= veto_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_gate_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_gate_gen
// Function : Scoreboard bench for trig_gate_gen against a schedule-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trig_gate_gen;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_pulse = 1'b0;
    logic             enable = 1'b0;
    logic [7:0]       cfg_delay = '0;
    logic [7:0]       cfg_width = '0;
    logic [7:0]       cfg_dead = '0;
    logic             count_clr = 1'b0;
    logic             gate_out;
    logic             busy;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] veto_cnt;

    trig_gate_gen #(.DLY_W(8), .WID_W(8), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_pulse   (in_pulse),
        .enable     (enable),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_dead   (cfg_dead),
        .count_clr  (count_clr),
        .gate_out   (gate_out),
        .busy       (busy),
        .accept_cnt (accept_cnt),
        .veto_cnt   (veto_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int  cyc;
        bit  g;
        bit  b;
        int  a;
        int  v;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: absolute cycle windows of the current gate and busy span.
    int m_cyc     = 0;
    int m_gate_lo = 0;
    int m_gate_hi = -1;
    int m_busy_hi = -1;
    int m_acc     = 0;
    int m_veto    = 0;

    // Inputs applied during cycle m_cyc; the expectation describes cycle m_cyc+1.
    task automatic drive(input bit rn, input bit p, input bit en, input bit clr,
                         input int d, input int w, input int e);
        exp_t x;
        bit   busy_now;
        int   weff;
        @(negedge clk);
        reset_n   = rn;
        in_pulse  = p;
        enable    = en;
        count_clr = clr;
        cfg_delay = 8'(d);
        cfg_width = 8'(w);
        cfg_dead  = 8'(e);
        busy_now  = (m_cyc <= m_busy_hi);
        if (!rn) begin
            m_acc     = 0;
            m_veto    = 0;
            m_busy_hi = m_cyc;
            m_gate_hi = m_cyc;
        end else begin
            if (p && en && !busy_now) begin
                weff      = (w == 0) ? 1 : w;
                m_gate_lo = m_cyc + 1 + d;
                m_gate_hi = m_cyc + d + weff;
                m_busy_hi = m_cyc + d + weff + e;
                if (m_acc < CMAX) m_acc++;
            end
            if (p && busy_now && m_veto < CMAX) m_veto++;
            if (clr) begin
                m_acc  = 0;
                m_veto = 0;
            end
        end
        x.cyc = m_cyc + 1;
        x.g   = (x.cyc >= m_gate_lo) && (x.cyc <= m_gate_hi);
        x.b   = (x.cyc <= m_busy_hi);
        x.a   = m_acc;
        x.v   = m_veto;
        q.push_back(x);
        m_cyc++;
    endtask

    task automatic idle(input int n, input bit en);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, en, 1'b0, 3, 2, 4);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_cmp++;
                if (gate_out !== x.g || busy !== x.b ||
                    accept_cnt !== CNT_W'(x.a) || veto_cnt !== CNT_W'(x.v)) begin
                    n_err++;
                    $display("FAIL cycle%0d: got gate=%b busy=%b acc=%0d veto=%0d, want gate=%b busy=%b acc=%0d veto=%0d",
                             x.cyc, gate_out, busy, accept_cnt, veto_cnt, x.g, x.b, x.a, x.v);
                end
            end
        end
    end

    initial begin : stimulus
        // reset, then basic timing + veto boundary: pulses at 10, 19, 20
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        idle(8, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 2, 4);
        idle(8, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 2, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 2, 4);
        idle(12, 1'b1);
        // zero config: accept, veto, accept
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0);
        idle(3, 1'b1);
        // config latch: width changed and enable dropped during DELAY
        drive(1'b1, 1'b1, 1'b1, 1'b0, 3, 2, 1);
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 3, 9, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 3, 9, 1);
        idle(3, 1'b1);
        // saturation, then clear coincident with an accepted pulse
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 0, 1, 0);
            idle(1, 1'b1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1, 2, 0);
        idle(5, 1'b1);
        // reset mid-gate, pulse right after release
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1, 5, 2);
        idle(3, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1, 5, 2);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2, 2, 2);
        idle(8, 1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 9) < 4),
                  ($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 5)));
        end
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
